// File: rtl/spi_reg_bridge.sv
// SPI mode-1 slave (MSB first) bridging a host to a flat word-addressed register map on SYS_CLK.
// Optional feature macro: SPI_FRAME_ERR_EN (aborted-frame counter and out-of-range read marker).

module spi_cmd_word #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] word,
    output logic              strobe
);
    logic [WORD_W-1:0] word_q, word_d;
    logic              strobe_q, strobe_d;

    always_comb begin
        word_d   = we ? wdata : word_q;
        strobe_d = we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            word_q   <= word_d;
            strobe_q <= strobe_d;
        end
    end

    assign word   = word_q;
    assign strobe = strobe_q;
endmodule

module spi_reg_bridge #(
    parameter int                WORD_W    = 16,
    parameter int                NUM_REGS  = 64,
    parameter int                ADDR_W    = 6,
    parameter int                CMD_BASE  = 24,
    parameter logic [WORD_W-1:0] IDLE_WORD = 16'h0003
) (
    input  logic                                 SYS_CLK,
    input  logic                                 SYS_RST,
    input  logic                                 SPI_CLK,
    input  logic                                 SSEL,
    input  logic                                 MOSI,
    output logic                                 MISO,
    input  logic [CMD_BASE*WORD_W-1:0]           STATUS_REG,
    output logic [(NUM_REGS-CMD_BASE)*WORD_W-1:0] CMD_REG,
    output logic [NUM_REGS-CMD_BASE-1:0]         WR_STROBE,
    output logic                                 BUSY,
    output logic [7:0]                           FRAME_ERR_CNT
);
    localparam int NUM_CMD = NUM_REGS - CMD_BASE;
    localparam int CNT_W   = $clog2(WORD_W);
`ifdef SPI_FRAME_ERR_EN
    localparam logic [WORD_W-1:0] OOR_WORD = ~IDLE_WORD;
`else
    localparam logic [WORD_W-1:0] OOR_WORD = IDLE_WORD;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_e;

    logic [2:0]                     sck_q, sck_d, ssel_q, ssel_d;
    logic [1:0]                     mosi_q, mosi_d;
    logic                           frame_q, frame_d, done_q, done_d;
    logic [CNT_W-1:0]               bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0]              rx_q, rx_d, tx_sh_q, tx_sh_d, tx_next_q, tx_next_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    state_e                         state_q, state_d;

    logic [NUM_CMD-1:0][WORD_W-1:0]  cmd_w;
    logic [NUM_CMD-1:0]              cmd_we;
    logic [NUM_REGS-1:0][WORD_W-1:0] reg_w;
    logic                            wr_en;
    logic [WORD_W-1:0]               rd_a, rd_addr;
    logic [ADDR_W-1:0]               rx_a;
    logic [1:0]                      op;
    logic                            sck_rise, sck_fall, ssel_fall, ssel_rise;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] v);
        return (int'(v) == NUM_REGS - 1) ? '0 : v + 1'b1;
    endfunction

    assign sck_rise  =  sck_q[1]  & ~sck_q[2];
    assign sck_fall  = ~sck_q[1]  &  sck_q[2];
    assign ssel_fall = ~ssel_q[1] &  ssel_q[2];
    assign ssel_rise =  ssel_q[1] & ~ssel_q[2];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_map
        if (i < CMD_BASE) begin : g_sts
            assign reg_w[i] = STATUS_REG[i*WORD_W +: WORD_W];
        end else begin : g_cmd
            assign reg_w[i] = cmd_w[i-CMD_BASE];
        end
    end

    assign op      = rx_q[WORD_W-1 -: 2];
    assign rx_a    = rx_q[ADDR_W-1:0];
    assign rd_a    = (int'(rx_a) < NUM_REGS) ? reg_w[rx_a] : OOR_WORD;
    assign rd_addr = (int'(addr_q) < NUM_REGS) ? reg_w[addr_q] : IDLE_WORD;
    assign wr_en   = done_q && (state_q == ST_WRITE);

    // Out-of-range and read-only addresses match no lane, so those writes drop silently.
    for (genvar j = 0; j < NUM_CMD; j++) begin : g_word
        assign cmd_we[j] = wr_en && (addr_q == ADDR_W'(j + CMD_BASE));
        spi_cmd_word #(.WORD_W(WORD_W)) u_word (
            .clk   (SYS_CLK),
            .rst   (SYS_RST),
            .we    (cmd_we[j]),
            .wdata (rx_q),
            .word  (cmd_w[j]),
            .strobe(WR_STROBE[j])
        );
    end

    always_comb begin
        sck_d     = {sck_q[1:0], SPI_CLK};
        ssel_d    = {ssel_q[1:0], SSEL};
        mosi_d    = {mosi_q[0], MOSI};
        frame_d   = frame_q;
        done_d    = 1'b0;
        bitcnt_d  = bitcnt_q;
        rx_d      = rx_q;
        tx_sh_d   = tx_sh_q;
        tx_next_d = tx_next_q;
        addr_d    = addr_q;
        state_d   = state_q;

        if (frame_q && sck_fall) begin
            rx_d = {rx_q[WORD_W-2:0], mosi_q[1]};
            if (bitcnt_q == CNT_W'(WORD_W - 1)) begin
                bitcnt_d = '0;
                done_d   = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + 1'b1;
            end
        end

        // The first bit of each word is already on MISO, so the word's first rise does not shift.
        if (frame_q && sck_rise && bitcnt_q != '0)
            tx_sh_d = {tx_sh_q[WORD_W-2:0], 1'b0};

        if (done_q) begin
            case (state_q)
                ST_IDLE: begin
                    tx_next_d = IDLE_WORD;
                    if (op == 2'b10) begin
                        state_d   = ST_READ;
                        tx_next_d = rd_a;
                        addr_d    = addr_inc(rx_a);
                    end else if (op == 2'b01) begin
                        state_d = ST_WRITE;
                        addr_d  = rx_a;
                    end
                end
                ST_READ: begin
                    tx_next_d = rd_addr;
                    addr_d    = addr_inc(addr_q);
                end
                ST_WRITE: begin
                    tx_next_d = rx_q;
                    addr_d    = addr_inc(addr_q);
                end
                default: state_d = ST_IDLE;
            endcase
            tx_sh_d = tx_next_d;
        end

        if (ssel_fall) begin
            frame_d  = 1'b1;
            bitcnt_d = '0;
            tx_sh_d  = tx_next_q;
        end
        if (ssel_rise)
            frame_d = 1'b0;

        // Outside a frame a late word still commits its write, but decode state is parked.
        if (!frame_d) begin
            state_d   = ST_IDLE;
            bitcnt_d  = '0;
            tx_next_d = IDLE_WORD;
        end
    end

    // Sync chains reset to "selected" so a reset under an active SSEL never looks like a new frame.
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            sck_q     <= '0;
            ssel_q    <= '0;
            mosi_q    <= '0;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
            bitcnt_q  <= '0;
            rx_q      <= '0;
            tx_sh_q   <= IDLE_WORD;
            tx_next_q <= IDLE_WORD;
            addr_q    <= '0;
            state_q   <= ST_IDLE;
        end else begin
            sck_q     <= sck_d;
            ssel_q    <= ssel_d;
            mosi_q    <= mosi_d;
            frame_q   <= frame_d;
            done_q    <= done_d;
            bitcnt_q  <= bitcnt_d;
            rx_q      <= rx_d;
            tx_sh_q   <= tx_sh_d;
            tx_next_q <= tx_next_d;
            addr_q    <= addr_d;
            state_q   <= state_d;
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic [7:0] ferr_q, ferr_d;

    always_comb begin
        ferr_d = ferr_q;
        if (ssel_rise && frame_q && bitcnt_q != '0 && ferr_q != 8'hFF)
            ferr_d = ferr_q + 8'd1;
        if (wr_en && addr_q == ADDR_W'(NUM_REGS - 1) && rx_q[WORD_W-1])
            ferr_d = '0;
    end

    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) ferr_q <= '0;
        else         ferr_q <= ferr_d;
    end

    assign FRAME_ERR_CNT = ferr_q;
`else
    assign FRAME_ERR_CNT = 8'd0;
`endif

    assign CMD_REG = cmd_w;
    assign MISO    = tx_sh_q[WORD_W-1];
    assign BUSY    = frame_q;
endmodule
